// File: rtl/reg_mux_n.sv
// reg_mux_n: registered N:1 mux with input tracking and out-of-range select flagging.
// Defining MUX_SCAN_EN adds the scan_en port and a SCAN_DIV divider that auto-steps out_ch.
module reg_mux_n #(
    parameter int WIDTH    = 32,
    parameter int NUM_IN   = 8,
    parameter int SCAN_DIV = 4,
    localparam int SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    input  logic                    hold,
`ifdef MUX_SCAN_EN
    input  logic                    scan_en,
`endif
    output logic [WIDTH-1:0]        out,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    output logic                    sel_err
);
    localparam logic [SEL_W:0]   NUM_W = (SEL_W + 1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_IN - 1);

    logic [WIDTH-1:0] chan [2**SEL_W];
    logic             accept, sel_ok, step;
    logic [SEL_W-1:0] next_ch;

    if (NUM_IN < 2 || NUM_IN > 64) begin : g_bad_num
        $error("reg_mux_n: NUM_IN must be in 2..64");
    end
    if (SCAN_DIV < 1) begin : g_bad_div
        $error("reg_mux_n: SCAN_DIV must be >= 1");
    end

    // Pad the channel table to a power of two so any select indexes a real entry.
    for (genvar c = 0; c < 2**SEL_W; c++) begin : g_chan
        if (c < NUM_IN) begin : g_used
            assign chan[c] = in_bus[c*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[c] = '0;
        end
    end

    assign accept  = sel_valid & ~hold;
    assign sel_ok  = {1'b0, sel} < NUM_W;
    assign next_ch = accept ? (sel_ok ? sel : '0)
                   : step   ? ((out_ch == LAST) ? '0 : out_ch + 1'b1)
                   : out_ch;

`ifdef MUX_SCAN_EN
    localparam int               DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div;

    assign step = scan_en & ~hold & ~sel_valid & (div == DIV_TC);

    always_ff @(posedge clk) begin
        if (reset)
            div <= '0;
        else if (!hold)
            div <= (accept | ~scan_en | step) ? '0 : div + 1'b1;
    end
`else
    assign step = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= accept & ~sel_ok;
            if (!hold) begin
                out       <= chan[next_ch];
                out_ch    <= next_ch;
                out_valid <= out_valid | accept | step;
            end
        end
    end
endmodule

// File: tb/tb_reg_mux_n.sv
// tb_reg_mux_n: random and directed checks of an 8-input and a 6-input reg_mux_n against a behavioural model.
module tb_reg_mux_n;
    localparam int SD = 4;
`ifdef MUX_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    typedef struct {
        logic [31:0] out;
        int          ch;
        bit          valid;
        bit          err;
        int          div;
    } st_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] in_bus = '0;
    logic [2:0]   sel = '0;
    logic         sel_valid = 1'b0;
    logic         hold = 1'b0;
    logic         scan_en = 1'b0;
    logic [31:0]  out8, out6;
    logic [2:0]   ch8, ch6;
    logic         val8, val6, err8, err6;
    st_t          m8, m6;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    reg_mux_n #(.WIDTH(32), .NUM_IN(8), .SCAN_DIV(SD)) d8 (
        .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .sel_valid(sel_valid), .hold(hold),
`ifdef MUX_SCAN_EN
        .scan_en(scan_en),
`endif
        .out(out8), .out_ch(ch8), .out_valid(val8), .sel_err(err8));

    reg_mux_n #(.WIDTH(32), .NUM_IN(6), .SCAN_DIV(SD)) d6 (
        .clk(clk), .reset(reset), .in_bus(in_bus[191:0]), .sel(sel), .sel_valid(sel_valid), .hold(hold),
`ifdef MUX_SCAN_EN
        .scan_en(scan_en),
`endif
        .out(out6), .out_ch(ch6), .out_valid(val6), .sel_err(err6));

    function automatic st_t model(st_t s, int n, logic [255:0] bus, int sl, bit sv, bit hl, bit rs, bit sc);
        st_t r = s;
        r.err = 1'b0;
        if (rs) return '{out: '0, ch: 0, valid: 1'b0, err: 1'b0, div: 0};
        if (hl) return r;
        if (sv) begin
            r.err = sl >= n;
            r.ch = (sl >= n) ? 0 : sl;
            r.valid = 1'b1;
            r.div = 0;
        end else if (sc) begin
            if (s.div == SD - 1) begin
                r.ch = (s.ch + 1) % n;
                r.valid = 1'b1;
                r.div = 0;
            end else r.div = s.div + 1;
        end else r.div = 0;
        r.out = bus[r.ch*32 +: 32];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cmp_all();
        chk("out8", out8, m8.out);
        chk("ch8", {29'b0, ch8}, 32'(m8.ch));
        chk("valid8", {31'b0, val8}, 32'(m8.valid));
        chk("err8", {31'b0, err8}, 32'(m8.err));
        chk("out6", out6, m6.out);
        chk("ch6", {29'b0, ch6}, 32'(m6.ch));
        chk("valid6", {31'b0, val6}, 32'(m6.valid));
        chk("err6", {31'b0, err6}, 32'(m6.err));
    endtask

    task automatic tick(input int s, input bit v, input bit h, input bit r, input bit sc);
        @(negedge clk);
        sel = 3'(s);
        sel_valid = v;
        hold = h;
        reset = r;
        scan_en = sc;
        @(posedge clk);
        m8 = model(m8, 8, in_bus, s, v, h, r, sc && SCAN);
        m6 = model(m6, 6, in_bus, s, v, h, r, sc && SCAN);
        #1 cmp_all();
    endtask

    task automatic rand_bus();
        for (int i = 0; i < 8; i++) in_bus[i*32 +: 32] = $urandom;
    endtask

    initial begin
        m8 = '{out: '0, ch: 0, valid: 1'b0, err: 1'b0, div: 0};
        m6 = m8;
        rand_bus();
        tick(0, 0, 0, 1, 0);
        rand_bus();
        tick(0, 0, 0, 1, 0);
        chk("rst_out", out8, 32'h0);
        chk("rst_valid", {31'b0, val8}, 32'h0);
        tick(0, 0, 0, 0, 0);
        chk("pre_accept_valid", {31'b0, val8}, 32'h0);

        in_bus[3*32 +: 32] = 32'hDEADBEEF;
        tick(3, 1, 0, 0, 0);
        chk("sel3_out", out8, 32'hDEADBEEF);
        chk("sel3_ch", {29'b0, ch8}, 32'd3);
        in_bus[3*32 +: 32] = 32'h12345678;
        tick(0, 0, 0, 0, 0);
        chk("track_out", out8, 32'h12345678);

        in_bus[3*32 +: 32] = 32'hCAFEF00D;
        tick(5, 1, 1, 0, 0);
        chk("hold_out", out8, 32'h12345678);
        chk("hold_ch", {29'b0, ch8}, 32'd3);
        in_bus[3*32 +: 32] = 32'h0BADC0DE;
        tick(5, 1, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("unhold_out", out8, 32'h0BADC0DE);
        chk("unhold_ch", {29'b0, ch8}, 32'd3);

        tick(7, 1, 0, 0, 0);
        chk("range6_ch", {29'b0, ch6}, 32'd0);
        chk("range6_err", {31'b0, err6}, 32'd1);
        chk("range6_out", out6, in_bus[31:0]);
        chk("range8_ch", {29'b0, ch8}, 32'd7);
        chk("range8_err", {31'b0, err8}, 32'd0);
        tick(0, 0, 0, 0, 0);
        chk("range6_pulse", {31'b0, err6}, 32'd0);

        tick(5, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        chk("midrst_ch", {29'b0, ch8}, 32'd0);
        chk("midrst_valid", {31'b0, val8}, 32'd0);
        tick(2, 1, 0, 0, 0);
        chk("postrst_ch", {29'b0, ch8}, 32'd2);
        chk("postrst_valid", {31'b0, val8}, 32'd1);

        if (SCAN) begin
            tick(6, 1, 0, 0, 0);
            for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1);
            chk("scan_ch7", {29'b0, ch8}, 32'd7);
            for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1);
            chk("scan_wrap", {29'b0, ch8}, 32'd0);
            tick(0, 0, 0, 0, 1);
            tick(0, 0, 0, 0, 1);
            tick(2, 1, 0, 0, 1);
            chk("scan_accept", {29'b0, ch8}, 32'd2);
            for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1);
            chk("scan_restart_wait", {29'b0, ch8}, 32'd2);
            tick(0, 0, 0, 0, 1);
            chk("scan_restart_step", {29'b0, ch8}, 32'd3);
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) rand_bus();
            tick(int'($urandom_range(0, 7)), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
